// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer slice.
// Direction and mode encodings match the cfg_down / cfg_reload input bits.
package count_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;
   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/count_seq_tick.sv
// Prescaler: raises tick on every PRESCALE-th enabled cycle.
// The clear input realigns the phase so the first tick follows a fresh start.
module count_seq_tick #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] count;

   assign tick = enable && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/count_sequencer.sv
// Controlled counter: start/stop FSM, captured configuration, prescaled stepping,
// terminal-count pulse and one-shot completion pulse. All outputs are registered.
module count_sequencer
   import count_seq_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] cfg_load,
   input  logic [WIDTH-1:0] cfg_term,
   input  logic             cfg_down,
   input  logic             cfg_reload,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   state_t           state, state_next;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] cap_load, cap_term;
   logic             cap_down, cap_reload;
   logic             tc_next;
   logic             accept;
   logic             tick;
   logic             tick_en;

   // Stop freezes the prescaler too, so a stopped cycle can never produce a step.
   assign tick_en = (state == RUN) && !stop;

   count_seq_tick #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accept),
      .enable (tick_en),
      .tick   (tick)
   );

   always_comb begin
      state_next = state;
      q_next     = q;
      tc_next    = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start && !stop) begin
               accept     = 1'b1;
               state_next = RUN;
               q_next     = cfg_load;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            if (stop) begin
               state_next = IDLE;
            end else if (tick) begin
               if (q == cap_term) begin
                  tc_next = 1'b1;
                  if (cap_reload == MODE_RELOAD) begin
                     q_next = cap_load;
                  end else begin
                     state_next = DONE;
                  end
               end else if (cap_down == DIR_DOWN) begin
                  q_next = q - WIDTH'(1);
               end else begin
                  q_next = q + WIDTH'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         q          <= '0;
         tc         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cap_load   <= '0;
         cap_term   <= '0;
         cap_down   <= 1'b0;
         cap_reload <= 1'b0;
      end else begin
         state <= state_next;
         q     <= q_next;
         tc    <= tc_next;
         busy  <= (state_next == RUN);
         done  <= (state_next == DONE);
         if (accept) begin
            cap_load   <= cfg_load;
            cap_term   <= cfg_term;
            cap_down   <= cfg_down;
            cap_reload <= cfg_reload;
         end
      end
   end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: two instances (PRESCALE 1 and 3) share stimulus and
// are compared every cycle against an elapsed-time reference model plus literal checks.
module tb_count_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, cfg_down, cfg_reload;
   logic [3:0] cfg_load, cfg_term;

   logic [3:0] q1, q3;
   logic       busy1, tc1, done1, busy3, tc3, done3;

   int checks = 0;
   int passes = 0;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   typedef struct {
      int         st;
      logic [3:0] q;
      logic [3:0] load;
      logic [3:0] term;
      bit         down;
      bit         reload;
      int         elapsed;
      bit         tc;
   } mdl_t;

   mdl_t m1, m3;

   always #5 clk = ~clk;

   count_sequencer #(.WIDTH(4), .PRESCALE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .cfg_load(cfg_load), .cfg_term(cfg_term), .cfg_down(cfg_down), .cfg_reload(cfg_reload),
      .q(q1), .busy(busy1), .tc(tc1), .done(done1)
   );

   count_sequencer #(.WIDTH(4), .PRESCALE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .cfg_load(cfg_load), .cfg_term(cfg_term), .cfg_down(cfg_down), .cfg_reload(cfg_reload),
      .q(q3), .busy(busy3), .tc(tc3), .done(done3)
   );

   function automatic mdl_t model_reset();
      mdl_t r;
      r.st = M_IDLE; r.q = 4'd0; r.load = 4'd0; r.term = 4'd0;
      r.down = 1'b0; r.reload = 1'b0; r.elapsed = 0; r.tc = 1'b0;
      return r;
   endfunction

   // Steps land on every multiple of p cycles since the accepted start.
   function automatic mdl_t model_step(mdl_t m, int p, bit s, bit sp,
                                       logic [3:0] ld, logic [3:0] tm, bit dn, bit rl);
      mdl_t n = m;
      n.tc = 1'b0;
      if (m.st == M_RUN) begin
         if (sp) begin
            n.st = M_IDLE;
         end else begin
            n.elapsed = m.elapsed + 1;
            if (n.elapsed % p == 0) begin
               if (m.q == m.term) begin
                  n.tc = 1'b1;
                  if (m.reload) n.q = m.load;
                  else n.st = M_DONE;
               end else begin
                  n.q = m.down ? m.q - 4'd1 : m.q + 4'd1;
               end
            end
         end
      end else if (s && !sp) begin
         n.st = M_RUN; n.load = ld; n.term = tm; n.down = dn; n.reload = rl;
         n.q = ld; n.elapsed = 0;
      end else begin
         n.st = M_IDLE;
      end
      return n;
   endfunction

   initial begin
      m1 = model_reset();
      m3 = model_reset();
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 = model_reset();
         m3 = model_reset();
      end else begin
         m1 = model_step(m1, 1, start, stop, cfg_load, cfg_term, cfg_down, cfg_reload);
         m3 = model_step(m3, 3, start, stop, cfg_load, cfg_term, cfg_down, cfg_reload);
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      check_output("m1_q",    32'(q1),    32'(m1.q));
      check_output("m1_busy", 32'(busy1), 32'(m1.st == M_RUN));
      check_output("m1_tc",   32'(tc1),   32'(m1.tc));
      check_output("m1_done", 32'(done1), 32'(m1.st == M_DONE));
      check_output("m3_q",    32'(q3),    32'(m3.q));
      check_output("m3_busy", 32'(busy3), 32'(m3.st == M_RUN));
      check_output("m3_tc",   32'(tc3),   32'(m3.tc));
      check_output("m3_done", 32'(done3), 32'(m3.st == M_DONE));
   end

   task automatic apply_stimulus(input bit s, input bit sp, input logic [3:0] ld,
                                 input logic [3:0] tm, input bit dn, input bit rl);
      start = s; stop = sp; cfg_load = ld; cfg_term = tm; cfg_down = dn; cfg_reload = rl;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         start = 1'b0; stop = 1'b0;
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0;
      cfg_load = 4'd0; cfg_term = 4'd0; cfg_down = 1'b0; cfg_reload = 1'b0;
      #11;
      check_output("reset_q",    32'(q1),    32'd0);
      check_output("reset_busy", 32'(busy1), 32'd0);
      check_output("reset_tc",   32'(tc1),   32'd0);
      check_output("reset_done", 32'(done1), 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #2;

      // One-shot up count 0..3
      apply_stimulus(1, 0, 4'd0, 4'd3, 0, 0);
      check_output("os_q_e0", 32'(q1), 32'd0);
      check_output("os_busy_e0", 32'(busy1), 32'd1);
      idle(1); check_output("os_q_e1", 32'(q1), 32'd1);
      idle(1); check_output("os_q_e2", 32'(q1), 32'd2);
      idle(1); check_output("os_q_e3", 32'(q1), 32'd3);
      check_output("os_tc_e3", 32'(tc1), 32'd0);
      idle(1);
      check_output("os_tc_e4", 32'(tc1), 32'd1);
      check_output("os_done_e4", 32'(done1), 32'd1);
      check_output("os_busy_e4", 32'(busy1), 32'd0);
      check_output("os_q_e4", 32'(q1), 32'd3);
      idle(1);
      check_output("os_tc_e5", 32'(tc1), 32'd0);
      check_output("os_done_e5", 32'(done1), 32'd0);
      check_output("os_q_e5", 32'(q1), 32'd3);

      // Rerun, then reset mid-run
      apply_stimulus(1, 0, 4'd0, 4'd3, 0, 0);
      idle(2);
      check_output("rr_q_e2", 32'(q1), 32'd2);
      rst_n = 1'b0;
      #1;
      check_output("rst_q1", 32'(q1), 32'd0);
      check_output("rst_busy1", 32'(busy1), 32'd0);
      check_output("rst_tc1", 32'(tc1), 32'd0);
      check_output("rst_done1", 32'(done1), 32'd0);
      check_output("rst_q3", 32'(q3), 32'd0);
      check_output("rst_busy3", 32'(busy3), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Down count with wrap, prescale 3 on dut3
      apply_stimulus(1, 0, 4'd1, 4'd14, 1, 0);
      check_output("dn_q3_e0", 32'(q3), 32'd1);
      check_output("dn_busy3_e0", 32'(busy3), 32'd1);
      idle(3); check_output("dn_q3_e3", 32'(q3), 32'd0);
      check_output("dn_q1_e3", 32'(q1), 32'd14);
      idle(3); check_output("dn_q3_e6", 32'(q3), 32'd15);
      idle(3); check_output("dn_q3_e9", 32'(q3), 32'd14);
      idle(2); check_output("dn_tc3_e11", 32'(tc3), 32'd0);
      idle(1);
      check_output("dn_tc3_e12", 32'(tc3), 32'd1);
      check_output("dn_done3_e12", 32'(done3), 32'd1);
      check_output("dn_busy3_e12", 32'(busy3), 32'd0);
      idle(1); check_output("dn_done3_e13", 32'(done3), 32'd0);

      // Auto-reload 5..7, start mid-run ignored
      apply_stimulus(1, 0, 4'd5, 4'd7, 0, 1);
      check_output("ar_q_e0", 32'(q1), 32'd5);
      idle(1); check_output("ar_q_e1", 32'(q1), 32'd6);
      idle(1); check_output("ar_q_e2", 32'(q1), 32'd7);
      idle(1);
      check_output("ar_tc_e3", 32'(tc1), 32'd1);
      check_output("ar_q_e3", 32'(q1), 32'd5);
      check_output("ar_busy_e3", 32'(busy1), 32'd1);
      apply_stimulus(1, 0, 4'd0, 4'd15, 1, 0);
      check_output("ar_q_e4", 32'(q1), 32'd6);
      idle(1); check_output("ar_q_e5", 32'(q1), 32'd7);
      idle(1);
      check_output("ar_tc_e6", 32'(tc1), 32'd1);
      check_output("ar_q_e6", 32'(q1), 32'd5);
      apply_stimulus(0, 1, 4'd0, 4'd15, 1, 0);
      check_output("ar_stop_busy", 32'(busy1), 32'd0);
      check_output("ar_stop_q", 32'(q1), 32'd5);

      // Stop coincident with terminal tick; start+stop together
      apply_stimulus(1, 0, 4'd0, 4'd2, 0, 0);
      idle(2); check_output("sp_q_e2", 32'(q1), 32'd2);
      apply_stimulus(0, 1, 4'd0, 4'd2, 0, 0);
      check_output("sp_tc", 32'(tc1), 32'd0);
      check_output("sp_done", 32'(done1), 32'd0);
      check_output("sp_busy", 32'(busy1), 32'd0);
      check_output("sp_q", 32'(q1), 32'd2);
      apply_stimulus(1, 1, 4'd9, 4'd9, 0, 0);
      check_output("ss_busy", 32'(busy1), 32'd0);
      check_output("ss_q", 32'(q1), 32'd2);

      // load = term, then restart from DONE
      apply_stimulus(1, 0, 4'd9, 4'd9, 0, 0);
      check_output("eq_q_e0", 32'(q1), 32'd9);
      idle(1);
      check_output("eq_tc_e1", 32'(tc1), 32'd1);
      check_output("eq_done_e1", 32'(done1), 32'd1);
      check_output("eq_q_e1", 32'(q1), 32'd9);
      apply_stimulus(1, 0, 4'd4, 4'd6, 0, 0);
      check_output("rd_busy", 32'(busy1), 32'd1);
      check_output("rd_q", 32'(q1), 32'd4);
      check_output("rd_done", 32'(done1), 32'd0);
      idle(2); check_output("rd_q_e2", 32'(q1), 32'd6);
      idle(1);
      check_output("rd_tc_e3", 32'(tc1), 32'd1);
      check_output("rd_done_e3", 32'(done1), 32'd1);
      idle(1);

      // load = term with reload: tc every tick, q stays put
      apply_stimulus(1, 0, 4'd9, 4'd9, 0, 1);
      idle(1);
      check_output("eqr_tc_e1", 32'(tc1), 32'd1);
      check_output("eqr_q_e1", 32'(q1), 32'd9);
      idle(1);
      check_output("eqr_tc_e2", 32'(tc1), 32'd1);
      check_output("eqr_busy_e2", 32'(busy1), 32'd1);
      apply_stimulus(0, 1, 4'd9, 4'd9, 0, 1);
      idle(10);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Synchronous controller that sequences a WIDTH-bit counter datapath: it accepts a start command with load, terminal and mode settings, steps the count at a prescaled rate, flags terminal count, and returns to idle or reloads. It replaces free-running ripple counting wherever the design needs a counter that is started, stopped and reloaded under control. All state is clocked on a single clock edge.

## Interface

Parameters:
- WIDTH, 4, counter width in bits (≥2)
- PRESCALE, 1, clock cycles per count step (≥1)

Ports:
- clk  input  1  single clock; all state on posedge
- rst_n  input  1  reset, asynchronous, active-low; one clock, no other reset
- start  input  1  start request; one-cycle strobe or level
- stop  input  1  abort request
- cfg_load  input  WIDTH  initial and reload value, captured on accepted start
- cfg_term  input  WIDTH  terminal value, captured on accepted start
- cfg_down  input  1  1 = count down, 0 = count up; captured on accepted start
- cfg_reload  input  1  1 = auto-reload at terminal, 0 = one-shot; captured on accepted start
- q  output  WIDTH  current count
- busy  output  1  high in RUN
- tc  output  1  one-cycle terminal-count pulse
- done  output  1  one-cycle completion pulse, one-shot mode only

## Operation

- States: IDLE, RUN, DONE.
- IDLE: start=1 and stop=0 → RUN; capture cfg_*; q←cfg_load; prescaler←0.
- RUN: prescaler increments every cycle; tick when prescaler = PRESCALE-1, then prescaler←0.
- On tick: if q = term: tc←1; if reload, q←load and stay in RUN; otherwise → DONE and q holds term. If q ≠ term: q←q±1 modulo 2^WIDTH.
- RUN with stop=1 → IDLE next edge; q holds its value; no tc, no done. Stop takes priority over a coincident tick.
- DONE: done=1 for exactly this cycle, then → IDLE. start in DONE is accepted as from IDLE; done still pulses.
- start during RUN is ignored; it does not restart or recapture cfg.
- start and stop in the same cycle: stop wins; no start is accepted.
- cfg_* changes outside an accepted start have no effect.
- Wrap: up from 2^WIDTH-1 → 0; down from 0 → 2^WIDTH-1; no error flag.
- load = term: tc fires on the first tick with no step.

## Timing

- Reset (rst_n low, asynchronous): state IDLE, q=0, busy=0, tc=0, done=0, prescaler=0, captured cfg=0. Reset asserted mid-RUN aborts immediately with no pulses. Release is synchronous to the first clk edge.
- All outputs are registered.
- Start accepted at edge E0 → busy=1, q=load from E0.
- Steps occur at E0+k·PRESCALE, for k≥1.
- Terminal reached after n steps → tc high for the cycle after edge E0+(n+1)·PRESCALE.
- One-shot: done and tc are high in the same cycle. busy is 0 in that cycle (DONE state); done deasserts at the next edge.
- Auto-reload: period is (n+1)·PRESCALE cycles, and tc pulses every period.

## Structure

- Package count_seq_pkg: state enum (IDLE, RUN, DONE) and direction/mode constants (DIR_UP, DIR_DOWN, MODE_ONESHOT, MODE_RELOAD).
- Sub-module count_seq_tick: prescaler with clk, rst_n, clear, enable → tick. Parameterised by PRESCALE; PRESCALE=1 gives tick every enabled cycle.
- Top level: FSM, config capture registers, and counter register.

## Test plan

- Reset mid-run: WIDTH=4, PRESCALE=1, load=0, term=3, up, one-shot, start at E0 → q=1,2,3 at E1–E3. Assert rst_n low at E2 in a rerun → all outputs 0 immediately, no tc or done.
- One-shot terminal: same config, no reset → tc=done=1 for the cycle after E4, busy=0 there, IDLE next cycle, q stays 3.
- Down count with wrap and prescale: PRESCALE=3, load=1, term=14, down → q 1,0,15,14 at E3, E6, E9; tc at E12.
- Auto-reload with late start: load=5, term=7, up → tc every 3 cycles; q sequence 5,6,7,5,…. Assert start mid-run → no change.
- Stop priority: stop coincident with the terminal tick → IDLE, no tc. start+stop together in IDLE → stays IDLE, q unchanged.
- load = term = 9 → tc after the first tick, q never leaves 9. start during DONE → restart accepted with done pulse still seen.
